// File: rtl/huffman_pkg.sv
// Shared constants and types for the Huffman code packer.
// The code table is kept as an array of code_entry_t, one per gray-level symbol.
package huffman_pkg;

  localparam int NSYM   = 6;
  localparam int CODE_W = 8;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 16;
  localparam int FILL_W = 5;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    WAIT_TBL,
    RUN,
    FLUSH,
    DONE
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] mask;
    logic [LEN_W-1:0]  len;
  } code_entry_t;

endpackage

// File: rtl/huff_code_len.sv
// Code length of a table entry: the number of ones in its right-aligned mask.
module huff_code_len
  import huffman_pkg::*;
(
  input  logic [CODE_W-1:0] mask,
  output logic [LEN_W-1:0]  len
);

  always_comb begin
    len = '0;
    for (int i = 0; i < CODE_W; i++) begin
      len = len + LEN_W'(mask[i]);
    end
  end

endmodule

// File: rtl/huffman_packer.sv
// Maps gray-level symbols to their Huffman codes and packs the codes MSB-first
// into a byte stream, zero-padding the final partial byte of each packet.
module huffman_packer
  import huffman_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] HC1,
  input  logic [CODE_W-1:0] HC2,
  input  logic [CODE_W-1:0] HC3,
  input  logic [CODE_W-1:0] HC4,
  input  logic [CODE_W-1:0] HC5,
  input  logic [CODE_W-1:0] HC6,
  input  logic [CODE_W-1:0] M1,
  input  logic [CODE_W-1:0] M2,
  input  logic [CODE_W-1:0] M3,
  input  logic [CODE_W-1:0] M4,
  input  logic [CODE_W-1:0] M5,
  input  logic [CODE_W-1:0] M6,
  input  logic              sym_valid,
  input  logic [7:0]        sym_data,
  input  logic              sym_last,
  output logic              sym_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              done,
  output logic [CNT_W-1:0]  bit_total,
  output logic              err
);

  state_t              state;
  logic                code_valid_q;
  logic [ACC_W-1:0]    acc;
  logic [FILL_W-1:0]   fill;
  code_entry_t         tbl [NSYM];

  logic [CODE_W-1:0]   hc_in  [NSYM];
  logic [CODE_W-1:0]   m_in   [NSYM];
  logic [LEN_W-1:0]    len_in [NSYM];

  logic                tbl_edge;
  logic                reload;
  logic                sym_fire;
  logic                byte_fire;
  logic                sym_legal;
  code_entry_t         sym_entry;
  logic [2:0]          sym_idx;
  logic [CODE_W-1:0]   sym_code;
  logic [FILL_W-1:0]   shamt;
  logic [ACC_W-1:0]    shifted;

  assign hc_in[0] = HC1;
  assign hc_in[1] = HC2;
  assign hc_in[2] = HC3;
  assign hc_in[3] = HC4;
  assign hc_in[4] = HC5;
  assign hc_in[5] = HC6;
  assign m_in[0]  = M1;
  assign m_in[1]  = M2;
  assign m_in[2]  = M3;
  assign m_in[3]  = M4;
  assign m_in[4]  = M5;
  assign m_in[5]  = M6;

  for (genvar g = 0; g < NSYM; g++) begin : g_len
    huff_code_len u_len (
      .mask (m_in[g]),
      .len  (len_in[g])
    );
  end

  // A reload is only honoured between packets, when no bits are pending.
  assign tbl_edge  = code_valid && !code_valid_q;
  assign reload    = (state == RUN) && (fill == '0) && tbl_edge;
  assign sym_ready = (state == RUN) && (fill < FILL_W'(8)) && !reload;
  assign out_valid = ((state == RUN)   && (fill >= FILL_W'(8))) ||
                     ((state == FLUSH) && (fill != '0));
  assign out_data  = acc[ACC_W-1 -: 8];
  assign done      = (state == DONE);
  assign sym_fire  = sym_valid && sym_ready;
  assign byte_fire = out_valid && out_ready;

  always_comb begin
    sym_entry = '0;
    sym_legal = 1'b0;
    sym_idx   = sym_data[2:0] - 3'd1;
    if ((sym_data != 8'd0) && (sym_data <= 8'(NSYM))) begin
      sym_entry = tbl[sym_idx];
      sym_legal = (sym_entry.len != '0);
    end
  end

  // New code lands just below the bits already held, left-aligned in acc.
  assign sym_code = sym_entry.code & sym_entry.mask;
  assign shamt    = FILL_W'(ACC_W) - fill - {1'b0, sym_entry.len};
  assign shifted  = {{(ACC_W-CODE_W){1'b0}}, sym_code} << shamt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= WAIT_TBL;
      code_valid_q <= 1'b0;
      acc          <= '0;
      fill         <= '0;
      bit_total    <= '0;
      err          <= 1'b0;
      for (int i = 0; i < NSYM; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      code_valid_q <= code_valid;
      case (state)
        WAIT_TBL: begin
          if (tbl_edge) begin
            for (int i = 0; i < NSYM; i++) begin
              tbl[i] <= '{code: hc_in[i], mask: m_in[i], len: len_in[i]};
            end
            bit_total <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (reload) begin
            for (int i = 0; i < NSYM; i++) begin
              tbl[i] <= '{code: hc_in[i], mask: m_in[i], len: len_in[i]};
            end
            bit_total <= '0;
          end else if (sym_fire) begin
            if (sym_legal) begin
              acc       <= acc | shifted;
              fill      <= fill + {1'b0, sym_entry.len};
              bit_total <= bit_total + CNT_W'(sym_entry.len);
            end else begin
              err <= 1'b1;
            end
            if (sym_last) begin
              state <= FLUSH;
            end
          end else if (byte_fire) begin
            acc  <= acc << 8;
            fill <= fill - FILL_W'(8);
          end
        end
        FLUSH: begin
          if (fill == '0) begin
            state <= DONE;
          end else if (byte_fire) begin
            if (fill > FILL_W'(8)) begin
              acc  <= acc << 8;
              fill <= fill - FILL_W'(8);
            end else begin
              acc   <= '0;
              fill  <= '0;
              state <= DONE;
            end
          end
        end
        DONE: begin
          bit_total <= '0;
          state     <= RUN;
        end
        default: state <= WAIT_TBL;
      endcase
    end
  end

endmodule

// File: doc/huffman_packer.md
Name: huffman_packer

Overview:
Downstream stage of the Huffman code generator. It latches the six-entry code table (HCn code, Mn mask) when code_valid rises. It then maps a stream of gray-level symbols (1..6) to their variable-length codes and packs them MSB-first into an 8-bit byte stream with a valid/ready handshake. At end of packet it zero-pads the last partial byte, pulses done and reports the total code-bit count.

Parameters:
NSYM, 6, number of symbols / table entries
CODE_W, 8, width of HCn/Mn; maximum code length
ACC_W, 16, bit accumulator width (must be >= 2*CODE_W)
CNT_W, 16, width of bit_total

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
code_valid  in  1  table valid from generator; table latched on its rising edge
HC1..HC6  in  8 each  code for symbol n, right-aligned
M1..M6  in  8 each  mask for symbol n, right-aligned ones; code length = popcount(Mn)
sym_valid  in  1  symbol present
sym_data  in  8  symbol value, legal 1..6
sym_last  in  1  qualifies the last symbol of a packet
sym_ready  out  1  symbol accepted when sym_valid&&sym_ready
out_valid  out  1  byte available
out_data  out  8  packed byte, first code bit in bit 7
out_ready  in  1  downstream accepts byte
done  out  1  one-cycle pulse after the final byte of a packet is accepted
bit_total  out  16  code bits appended in current/last packet, padding excluded
err  out  1  sticky illegal-symbol flag

Behaviour:
- Reset (async): state WAIT_TBL; acc=0, fill=0, table=0; every output 0.
- WAIT_TBL: sym_ready=0, out_valid=0. code_valid_q is the registered code_valid. When code_valid && !code_valid_q, latch HC/M and precompute len[n]=popcount(Mn). Next cycle go to RUN with bit_total=0.
- RUN: sym_ready = (fill < 8); out_valid = (fill >= 8). These two are mutually exclusive, so append and emit never occur in the same cycle.
- Append: on accept of a legal symbol s, c=HCs&Ms, L=len[s]. acc |= c << (ACC_W-fill-L); fill += L; bit_total += L. fill<8 and L<=8 guarantee no overflow (fill<=15).
- Illegal symbol: sym_data 0 or >6, or len[s]=0. The symbol is still handshaken and consumed, appends no bits, and sets err=1. err clears only on reset.
- Emit: out_data = acc[15:8] (registered value). On out_valid&&out_ready: acc <<= 8, fill -= 8. While out_valid && !out_ready, out_data and fill hold unchanged.
- sym_last on an accepted symbol, legal or not: append if legal, then go to FLUSH.
- FLUSH: sym_ready=0; out_valid = (fill != 0).
  - fill>=8: emit as in RUN.
  - 0<fill<8: emit acc[15:8], which is zero-padded in its low bits; then fill=0, acc=0.
  - fill==0: go to DONE.
- DONE (1 cycle): done=1, then return to RUN with the same table and bit_total cleared on re-entry. bit_total holds its final value through the done cycle.
- Table reload: only a new code_valid rising edge, sampled in any state, forces WAIT_TBL reload when state is RUN with fill==0. In FLUSH the edge is ignored.
- Latency: a symbol's bits are visible in out_data at the earliest the cycle after the accept that brings fill >= 8.

Decomposition:
- Package huffman_pkg: NSYM, CODE_W, ACC_W, CNT_W constants; state enum {WAIT_TBL, RUN, FLUSH, DONE}; code-table entry struct {code, mask, len}.
- One sub-module huff_code_len: combinational popcount of an 8-bit mask producing a 4-bit length, instantiated once per table entry at load.
- The FSM and accumulator stay in huffman_packer.

Test Plan:
Table used by all scenarios: HC=1/M=01 (sym1 "1"), 1/03 ("01"), 1/07 ("001"), 1/0F ("0001"), 1/1F ("00001"), 0/1F (sym6 "00000"); out_ready=1 unless stated.
1. Eight sym 1, last on the 8th -> one byte 0xFF, bit_total=8, done pulse one cycle after byte accept, err=0.
2. sym 6 then 5 (last) -> bytes 0x00, 0x40 (padded); bit_total=10; done once.
3. sym 2, 3 (last) -> single byte 0x48; bit_total=5.
4. Backpressure: stream 6,6,6,… with out_ready=0 for 5 cycles once fill>=8 -> sym_ready=0 throughout, out_data stable 0x00, no symbols lost after out_ready=1 resumes.
5. Stream 1, 0, 7, 1 (last) -> sym 0 and 7 consumed, err=1, output byte 0xC0, bit_total=2.
6. Assert reset mid-RUN with fill=5 -> all outputs 0 immediately, sym_ready=0; no output until a new code_valid rising edge reloads the table.
